// File: rtl/axi4_s_rd_fifo_credit_if.sv
// AXI4-lite read-channel bundle (AR + R) between a master and the slave-side read buffer.
interface axi4_s_rd_fifo_credit_if #(
   parameter int unsigned A_W = 32,
   parameter int unsigned D_W = 32
);
   logic [A_W-1:0] s_araddr;
   logic [2:0]     s_arprot;
   logic           s_arvalid;
   logic           s_arready;
   logic [D_W-1:0] s_rdata;
   logic [1:0]     s_rresp;
   logic           s_rvalid;
   logic           s_rready;

   modport master (
      output s_araddr, s_arprot, s_arvalid, s_rready,
      input  s_arready, s_rdata, s_rresp, s_rvalid
   );

   modport slave (
      input  s_araddr, s_arprot, s_arvalid, s_rready,
      output s_arready, s_rdata, s_rresp, s_rvalid
   );
endinterface

// File: rtl/axi4_s_rd_fifo_credit.sv
// AXI4-lite slave read buffer: AR FIFO to backend, R FIFO to master, credit-limited AR acceptance.
// Optional statistics counters are enabled with `define AXI4_S_RD_FIFO_STATS_EN.
module axi4_s_rd_fifo_credit #(
   parameter int unsigned A_W      = 32,
   parameter int unsigned D_W      = 32,
   parameter int unsigned AR_DEPTH = 4,
   parameter int unsigned R_DEPTH  = 4
) (
   input  logic                           aclk,
   input  logic                           reset,
   axi4_s_rd_fifo_credit_if.slave         s_axi,
   input  logic                           ar_rd_en,
   output logic                           ar_rd_empty,
   output logic [A_W-1:0]                 ar_addr,
   output logic [2:0]                     ar_prot,
   input  logic                           r_wr_en,
   input  logic [D_W-1:0]                 r_data,
   input  logic [1:0]                     r_resp,
   output logic                           r_wr_full,
   output logic [$clog2(R_DEPTH+1)-1:0]   outstanding,
`ifdef AXI4_S_RD_FIFO_STATS_EN
   output logic [31:0]                    stat_ar_cnt,
   output logic [31:0]                    stat_r_cnt,
   output logic [31:0]                    stat_err_resp_cnt,
`endif
   output logic                           err_sticky
);
   localparam int unsigned ArAw = $clog2(AR_DEPTH);
   localparam int unsigned ArPw = ArAw + 1;
   localparam int unsigned RAw  = $clog2(R_DEPTH);
   localparam int unsigned RPw  = RAw + 1;
   localparam int unsigned OutW = $clog2(R_DEPTH + 1);
   localparam int unsigned ArEw = A_W + 3;
   localparam int unsigned REw  = D_W + 2;

   logic [ArEw-1:0] ar_mem_q [AR_DEPTH];
   logic [ArEw-1:0] ar_mem_d [AR_DEPTH];
   logic [REw-1:0]  r_mem_q  [R_DEPTH];
   logic [REw-1:0]  r_mem_d  [R_DEPTH];
   logic [ArPw-1:0] ar_wptr_q, ar_wptr_d, ar_rptr_q, ar_rptr_d;
   logic [RPw-1:0]  r_wptr_q, r_wptr_d, r_rptr_q, r_rptr_d;
   logic [OutW-1:0] outstanding_q, outstanding_d;
   logic [OutW-1:0] bpend_q, bpend_d;
   logic            err_q, err_d;

   logic ar_empty, ar_full, r_empty, r_full;
   logic arready, rvalid;
   logic ar_push, ar_pop, r_push, r_pop, bpend_dec;
   logic [REw-1:0] r_head;
   logic [ArEw-1:0] ar_head;

   assign ar_empty = (ar_wptr_q == ar_rptr_q);
   assign ar_full  = (ar_wptr_q[ArAw] != ar_rptr_q[ArAw]) &&
                     (ar_wptr_q[ArAw-1:0] == ar_rptr_q[ArAw-1:0]);
   assign r_empty  = (r_wptr_q == r_rptr_q);
   assign r_full   = (r_wptr_q[RAw] != r_rptr_q[RAw]) &&
                     (r_wptr_q[RAw-1:0] == r_rptr_q[RAw-1:0]);

   // Full/credit state comes only from registers, so a same-cycle pop never frees space early.
   assign arready = !ar_full && (outstanding_q < OutW'(R_DEPTH)) && !reset;
   assign rvalid  = !r_empty && !reset;

   assign ar_push   = s_axi.s_arvalid && arready;
   assign ar_pop    = ar_rd_en && !ar_empty;
   assign r_push    = r_wr_en && !r_full;
   assign r_pop     = rvalid && s_axi.s_rready;
   assign bpend_dec = r_push && ((bpend_q != '0) || ar_pop);

   assign ar_head = ar_mem_q[ar_rptr_q[ArAw-1:0]];
   assign r_head  = r_mem_q[r_rptr_q[RAw-1:0]];

   assign s_axi.s_arready = arready;
   assign s_axi.s_rvalid  = rvalid;
   assign s_axi.s_rdata   = r_head[D_W-1:0];
   assign s_axi.s_rresp   = r_head[REw-1:D_W];
   assign ar_rd_empty     = ar_empty;
   assign ar_addr         = ar_head[A_W-1:0];
   assign ar_prot         = ar_head[ArEw-1:A_W];
   assign r_wr_full       = r_full;
   assign outstanding     = outstanding_q;
   assign err_sticky      = err_q;

   always_comb begin
      ar_mem_d      = ar_mem_q;
      r_mem_d       = r_mem_q;
      ar_wptr_d     = ar_wptr_q;
      ar_rptr_d     = ar_rptr_q;
      r_wptr_d      = r_wptr_q;
      r_rptr_d      = r_rptr_q;
      outstanding_d = outstanding_q;
      bpend_d       = bpend_q;
      err_d         = err_q;

      if (ar_push) begin
         ar_mem_d[ar_wptr_q[ArAw-1:0]] = {s_axi.s_arprot, s_axi.s_araddr};
         ar_wptr_d = ar_wptr_q + ArPw'(1);
      end
      if (ar_pop) begin
         ar_rptr_d = ar_rptr_q + ArPw'(1);
      end
      if (r_push) begin
         r_mem_d[r_wptr_q[RAw-1:0]] = {r_resp, r_data};
         r_wptr_d = r_wptr_q + RPw'(1);
      end
      if (r_pop) begin
         r_rptr_d = r_rptr_q + RPw'(1);
      end

      // Floor at zero so a stray backend response cannot wrap the credit count.
      if (ar_push && !r_pop) begin
         outstanding_d = outstanding_q + OutW'(1);
      end else if (!ar_push && r_pop && (outstanding_q != '0)) begin
         outstanding_d = outstanding_q - OutW'(1);
      end

      if (ar_pop && !bpend_dec && (bpend_q != '1)) begin
         bpend_d = bpend_q + OutW'(1);
      end else if (!ar_pop && bpend_dec) begin
         bpend_d = bpend_q - OutW'(1);
      end

      if ((ar_rd_en && ar_empty) || (r_wr_en && r_full) ||
          (r_push && (bpend_q == '0) && !ar_pop)) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge aclk) begin
      ar_mem_q <= ar_mem_d;
      r_mem_q  <= r_mem_d;
   end

   always_ff @(posedge aclk) begin
      if (reset) begin
         ar_wptr_q     <= '0;
         ar_rptr_q     <= '0;
         r_wptr_q      <= '0;
         r_rptr_q      <= '0;
         outstanding_q <= '0;
         bpend_q       <= '0;
         err_q         <= 1'b0;
      end else begin
         ar_wptr_q     <= ar_wptr_d;
         ar_rptr_q     <= ar_rptr_d;
         r_wptr_q      <= r_wptr_d;
         r_rptr_q      <= r_rptr_d;
         outstanding_q <= outstanding_d;
         bpend_q       <= bpend_d;
         err_q         <= err_d;
      end
   end

`ifdef AXI4_S_RD_FIFO_STATS_EN
   logic [31:0] stat_ar_cnt_q, stat_ar_cnt_d;
   logic [31:0] stat_r_cnt_q, stat_r_cnt_d;
   logic [31:0] stat_err_resp_cnt_q, stat_err_resp_cnt_d;

   always_comb begin
      stat_ar_cnt_d       = stat_ar_cnt_q;
      stat_r_cnt_d        = stat_r_cnt_q;
      stat_err_resp_cnt_d = stat_err_resp_cnt_q;
      if (ar_push && (stat_ar_cnt_q != '1)) begin
         stat_ar_cnt_d = stat_ar_cnt_q + 32'd1;
      end
      if (r_pop && (stat_r_cnt_q != '1)) begin
         stat_r_cnt_d = stat_r_cnt_q + 32'd1;
      end
      if (r_pop && r_head[REw-1] && (stat_err_resp_cnt_q != '1)) begin
         stat_err_resp_cnt_d = stat_err_resp_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge aclk) begin
      if (reset) begin
         stat_ar_cnt_q       <= '0;
         stat_r_cnt_q        <= '0;
         stat_err_resp_cnt_q <= '0;
      end else begin
         stat_ar_cnt_q       <= stat_ar_cnt_d;
         stat_r_cnt_q        <= stat_r_cnt_d;
         stat_err_resp_cnt_q <= stat_err_resp_cnt_d;
      end
   end

   assign stat_ar_cnt       = stat_ar_cnt_q;
   assign stat_r_cnt        = stat_r_cnt_q;
   assign stat_err_resp_cnt = stat_err_resp_cnt_q;
`endif
endmodule

// File: tb/tb_axi4_s_rd_fifo_credit.sv
// Directed bench for axi4_s_rd_fifo_credit with an in-order read-data scoreboard.
module tb_axi4_s_rd_fifo_credit;
   localparam int unsigned A_W = 32;
   localparam int unsigned D_W = 32;
   localparam int unsigned OW  = 3;

   logic           aclk = 1'b0;
   logic           reset = 1'b1;
   logic           ar_rd_en = 1'b0;
   logic           ar_rd_empty;
   logic [A_W-1:0] ar_addr;
   logic [2:0]     ar_prot;
   logic           r_wr_en = 1'b0;
   logic [D_W-1:0] r_data = '0;
   logic [1:0]     r_resp = '0;
   logic           r_wr_full;
   logic [OW-1:0]  outstanding;
   logic           err_sticky;
`ifdef AXI4_S_RD_FIFO_STATS_EN
   logic [31:0]    stat_ar_cnt, stat_r_cnt, stat_err_resp_cnt;
`endif

   axi4_s_rd_fifo_credit_if #(.A_W(A_W), .D_W(D_W)) axi ();

   axi4_s_rd_fifo_credit #(.A_W(A_W), .D_W(D_W), .AR_DEPTH(4), .R_DEPTH(4)) dut (
      .aclk        (aclk),
      .reset       (reset),
      .s_axi       (axi.slave),
      .ar_rd_en    (ar_rd_en),
      .ar_rd_empty (ar_rd_empty),
      .ar_addr     (ar_addr),
      .ar_prot     (ar_prot),
      .r_wr_en     (r_wr_en),
      .r_data      (r_data),
      .r_resp      (r_resp),
      .r_wr_full   (r_wr_full),
      .outstanding (outstanding),
`ifdef AXI4_S_RD_FIFO_STATS_EN
      .stat_ar_cnt       (stat_ar_cnt),
      .stat_r_cnt        (stat_r_cnt),
      .stat_err_resp_cnt (stat_err_resp_cnt),
`endif
      .err_sticky  (err_sticky)
   );

   always #5 aclk = ~aclk;

   int checks = 0;
   int errors = 0;
   logic [A_W+2:0] ar_q  [$];
   logic [D_W+1:0] exp_q [$];
   logic [A_W-1:0] bq    [$];
   logic [A_W-1:0] nxt_addr = 32'h10;
   int  mo = 0;
   int  ar_acc = 0;
   int  r_acc = 0;
   bit  auto_be = 1'b0;
   bit  be_pop = 1'b0;
   bit  be_push = 1'b0;

   function automatic logic [D_W-1:0] rdata_of(input logic [A_W-1:0] a);
      return {16'hA5A5, 4'h0, a[15:4]};
   endfunction

   function automatic logic [1:0] resp_of(input logic [A_W-1:0] a);
      return a[9:8];
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: drive backend, score handshakes before the edge, check credit model after it.
   task automatic cyc();
      logic [A_W+2:0] a;
      logic [D_W+1:0] e;
      if (auto_be) begin
         be_pop  = !ar_rd_empty;
         be_push = (bq.size() != 0) && !r_wr_full;
      end
      ar_rd_en = be_pop;
      r_wr_en  = be_push;
      axi.s_araddr = nxt_addr;
      axi.s_arprot = nxt_addr[6:4];
      if (bq.size() != 0) begin
         r_data = rdata_of(bq[0]);
         r_resp = resp_of(bq[0]);
      end else begin
         r_data = 32'hBAD0_BAD0;
         r_resp = 2'b00;
      end
      #1;
      if (!reset) begin
         if (axi.s_arvalid && axi.s_arready) begin
            ar_q.push_back({axi.s_arprot, axi.s_araddr});
            exp_q.push_back({resp_of(axi.s_araddr), rdata_of(axi.s_araddr)});
            mo++;
            ar_acc++;
            nxt_addr = nxt_addr + 32'h10;
         end
         if (ar_rd_en && !ar_rd_empty) begin
            chk("ar_pop_expected", 64'(ar_q.size() != 0), 64'd1);
            if (ar_q.size() != 0) begin
               a = ar_q.pop_front();
               chk("ar_head", {ar_prot, ar_addr}, a);
               bq.push_back(ar_addr);
            end
         end
         if (r_wr_en && !r_wr_full && (bq.size() != 0)) void'(bq.pop_front());
         if (axi.s_rvalid && axi.s_rready) begin
            chk("r_beat_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("r_beat", {axi.s_rresp, axi.s_rdata}, e);
               mo--;
               r_acc++;
            end
         end
      end
      @(posedge aclk);
      #1;
      if (reset) begin
         ar_q.delete();
         exp_q.delete();
         bq.delete();
         mo = 0;
      end
      chk("outstanding", outstanding, mo);
      if (!auto_be) begin
         be_pop  = 1'b0;
         be_push = 1'b0;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      cyc();
   endtask

   task automatic drain(input string tag);
      axi.s_arvalid = 1'b0;
      axi.s_rready  = 1'b1;
      auto_be = 1'b1;
      for (int i = 0; i < 40 && ((exp_q.size() != 0) || (outstanding != 0)); i++) cyc();
      auto_be = 1'b0;
      be_pop  = 1'b0;
      be_push = 1'b0;
      axi.s_rready = 1'b0;
      cyc();
      chk({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
      chk({tag, "_rvalid_low"}, axi.s_rvalid, 1'b0);
   endtask

   initial begin
      int acc0;
      axi.s_araddr  = '0;
      axi.s_arprot  = '0;
      axi.s_arvalid = 1'b0;
      axi.s_rready  = 1'b0;

      // Reset state
      cyc();
      cyc();
      chk("rst_arready", axi.s_arready, 1'b0);
      chk("rst_rvalid", axi.s_rvalid, 1'b0);
      reset = 1'b0;
      cyc();
      chk("rst_ar_empty", ar_rd_empty, 1'b1);
      chk("rst_r_full", r_wr_full, 1'b0);
      chk("rst_err", err_sticky, 1'b0);
      chk("rst_arready_rel", axi.s_arready, 1'b1);

      // Single read of 0x10, data A5A5_0001 resp 0
      nxt_addr = 32'h10;
      axi.s_arvalid = 1'b1;
      cyc();
      axi.s_arvalid = 1'b0;
      chk("single_ar_visible", ar_rd_empty, 1'b0);
      chk("single_ar_addr", ar_addr, 32'h10);
      be_pop = 1'b1;
      cyc();
      be_push = 1'b1;
      cyc();
      chk("single_rvalid", axi.s_rvalid, 1'b1);
      chk("single_rdata", axi.s_rdata, 32'hA5A5_0001);
      chk("single_out1", outstanding, 3'd1);
      axi.s_rready = 1'b1;
      cyc();
      axi.s_rready = 1'b0;
      chk("single_out0", outstanding, 3'd0);

      // Five back-to-back ARs with no R or backend activity: credit/AR-full limit at 4
      nxt_addr = 32'h20;
      acc0 = ar_acc;
      axi.s_arvalid = 1'b1;
      for (int i = 0; i < 5; i++) cyc();
      chk("b2b_accepted", 64'(ar_acc - acc0), 64'd4);
      chk("b2b_arready", axi.s_arready, 1'b0);
      chk("b2b_out4", outstanding, 3'd4);
      be_pop = 1'b1;
      cyc();
      chk("pop_still_blocked", axi.s_arready, 1'b0);
      be_push = 1'b1;
      cyc();
      chk("push_still_blocked", axi.s_arready, 1'b0);
      axi.s_rready = 1'b1;
      cyc();
      axi.s_rready = 1'b0;
      chk("credit_freed", axi.s_arready, 1'b1);
      drain("b2b");

      // Steady state: simultaneous AR and R handshakes every cycle
      do_reset();
      acc0 = r_acc;
      axi.s_arvalid = 1'b1;
      axi.s_rready  = 1'b1;
      auto_be = 1'b1;
      for (int i = 0; i < 4; i++) cyc();
      for (int i = 0; i < 20; i++) begin
         cyc();
         chk("steady_out", outstanding, 3'd3);
      end
      chk("steady_r_beats", 64'(r_acc - acc0), 64'd21);
      drain("steady");

      // Pop on empty AR FIFO
      do_reset();
      be_pop = 1'b1;
      cyc();
      chk("err_pop_empty", err_sticky, 1'b1);
      chk("err_pop_still_empty", ar_rd_empty, 1'b1);
      do_reset();
      chk("err_cleared", err_sticky, 1'b0);

      // Push on full R FIFO: dropped, contents intact
      nxt_addr = 32'h40;
      axi.s_arvalid = 1'b1;
      for (int i = 0; i < 4; i++) cyc();
      axi.s_arvalid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         be_pop = 1'b1;
         cyc();
      end
      for (int i = 0; i < 4; i++) begin
         be_push = 1'b1;
         cyc();
      end
      chk("r_full", r_wr_full, 1'b1);
      chk("no_err_yet", err_sticky, 1'b0);
      be_push = 1'b1;
      cyc();
      chk("err_push_full", err_sticky, 1'b1);
      axi.s_rready = 1'b1;
      #1;
      chk("no_pop_through", r_wr_full, 1'b1);
      drain("full");
      chk("err_held", err_sticky, 1'b1);

      // Response pushed with no popped read: accepted, flagged
      do_reset();
      be_push = 1'b1;
      cyc();
      chk("err_spurious", err_sticky, 1'b1);
      chk("spurious_accepted", axi.s_rvalid, 1'b1);

      // Error-response beat, then reset with three reads outstanding
      do_reset();
      nxt_addr = 32'h200;
      axi.s_arvalid = 1'b1;
      cyc();
      axi.s_arvalid = 1'b0;
      be_pop = 1'b1;
      cyc();
      be_push = 1'b1;
      cyc();
      chk("errresp_rresp", axi.s_rresp, 2'b10);
      axi.s_rready = 1'b1;
      cyc();
      axi.s_rready = 1'b0;
`ifdef AXI4_S_RD_FIFO_STATS_EN
      chk("stat_ar", stat_ar_cnt, 32'd1);
      chk("stat_r", stat_r_cnt, 32'd1);
      chk("stat_err_resp", stat_err_resp_cnt, 32'd1);
`endif
      nxt_addr = 32'h300;
      axi.s_arvalid = 1'b1;
      for (int i = 0; i < 3; i++) cyc();
      axi.s_arvalid = 1'b0;
      be_pop = 1'b1;
      cyc();
      be_push = 1'b1;
      cyc();
      chk("pre_rst_out3", outstanding, 3'd3);
      chk("pre_rst_rvalid", axi.s_rvalid, 1'b1);
      reset = 1'b1;
      #1;
      chk("in_rst_rvalid", axi.s_rvalid, 1'b0);
      chk("in_rst_arready", axi.s_arready, 1'b0);
      cyc();
      chk("post_rst_out", outstanding, 3'd0);
      chk("post_rst_ar_empty", ar_rd_empty, 1'b1);
`ifdef AXI4_S_RD_FIFO_STATS_EN
      chk("post_rst_stat_ar", stat_ar_cnt, 32'd0);
      chk("post_rst_stat_err", stat_err_resp_cnt, 32'd0);
`endif
      reset = 1'b0;
      axi.s_rready = 1'b1;
      cyc();
      chk("rel_rvalid", axi.s_rvalid, 1'b0);
      chk("rel_ar_empty", ar_rd_empty, 1'b1);
      chk("rel_arready", axi.s_arready, 1'b1);
      chk("rel_err", err_sticky, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
